ifu_pc_seq: RTL and testbench
=============================

Name: ifu_pc_seq

Overview:
Multi-cycle fetch sequencer with PC register, upstream of the CSR unit and the execute/decode path. Issues instruction-memory requests with a valid/ready handshake and holds the fetched instruction for execute. Waits for execute to commit, then selects the next PC. Sources for the next PC are:
- trap redirect, where the CSR unit's read data carries mtvec on ecall or mepc on mret;
- taken branch or jump;
- sequential pc+4.
Also keeps the retired-instruction count that the CSR unit will later expose as minstret.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded by reset; first fetch address.
XLEN, 32, datapath width for PC and instruction.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  XLEN  fetch address (= pc)
imem_req_ready  in  1  memory accepts request this cycle
imem_rsp_valid  in  1  instruction data valid this cycle
imem_rsp_data  in  32  returned instruction
pc  out  XLEN  PC of the instruction being fetched or executed
inst  out  32  captured instruction
inst_valid  out  1  inst is valid for execute (state EXEC)
exec_done  in  1  execute commits current instruction this cycle
br_taken  in  1  branch/jal/jalr taken
br_target  in  XLEN  branch/jump target
jump_ecall  in  1  current instruction is ecall
jump_mret  in  1  current instruction is mret
trap_target  in  XLEN  CSR read data (mtvec on ecall, mepc on mret)
instret  out  64  retired-instruction count

Behaviour:
- Reset (rst=1 at rising edge):
  - state=BOOT, pc=RESET_PC, inst=32'h0000_0013 (nop), instret=0.
  - Outputs while in BOOT: imem_req_valid=0, inst_valid=0, imem_req_addr=pc.
- States:
  - BOOT -> REQ unconditionally (one cycle).
  - REQ: imem_req_valid=1, imem_req_addr=pc, held stable until accepted. If imem_req_ready -> WAIT, else stay in REQ.
  - WAIT: if imem_rsp_valid, capture inst<=imem_rsp_data and go to EXEC; else stay in WAIT (no timeout).
  - EXEC: inst_valid=1, and inst/pc are held stable. If exec_done, update pc<=next_pc, instret<=instret+1, go to REQ. Else stay in EXEC.
- Outputs are Moore decodes of state: imem_req_valid=(state==REQ), inst_valid=(state==EXEC).
- Latency: minimum 3 cycles per instruction, REQ->WAIT->EXEC->REQ, with zero-wait memory and exec_done asserted on the first EXEC cycle.
- imem_rsp_valid is sampled only in WAIT. A response in BOOT, REQ or EXEC is ignored. The memory returns data no earlier than the cycle after acceptance.
- br_taken, jump_ecall, jump_mret and trap_target are sampled only in EXEC with exec_done=1; they are ignored otherwise.
- next_pc priority:
  1. jump_ecall -> trap_target
  2. jump_mret -> trap_target
  3. br_taken -> br_target
  4. otherwise pc+4
- If ecall and mret are both asserted, ecall wins. Any redirect overrides br_taken.
- next_pc[1:0] is forced to 2'b00. pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0).
- instret wraps 2^64-1 -> 0. It counts ecall and mret as retired.
- Reset mid-operation takes priority in any state: return to BOOT with the reset values above. A memory response still outstanding after reset is dropped, because it is only accepted in WAIT. The memory shares rst, so there are no stale responses.
- No combinational path from imem_rsp_* to imem_req_*.

Decomposition:
- Package ifu_pkg holds:
  - state enum BOOT/REQ/WAIT/EXEC (2 bits);
  - RESET_PC default;
  - NOP_INST=32'h0000_0013;
  - PC_STEP=4.
- One combinational sub-module, ifu_next_pc, implements the next_pc priority mux and alignment. It is unit-testable on its own.
- The FSM, PC, inst and instret registers stay in ifu_pc_seq.

Test Plan:
- Reset then idle memory: rst=1 for 2 cycles, then 0.
  - In BOOT: imem_req_valid=0, pc=32'h8000_0000, inst=32'h13, instret=0.
  - Next cycle: req_valid=1, addr=32'h8000_0000.
- Zero-wait sequential fetch of 3 instructions with exec_done on the first EXEC cycle: addresses 8000_0000, 8000_0004, 8000_0008, one every 3 cycles; instret=3.
- Backpressure:
  - imem_req_ready=0 for 4 cycles: addr stays stable, no state advance.
  - imem_rsp_valid pulsed while in REQ: ignored, inst unchanged.
  - rsp arrives 5 cycles after acceptance: inst captured, inst_valid=1.
- Ecall in EXEC with exec_done=1, trap_target=32'h8000_0100, br_taken=1, br_target=32'h8000_0200: next addr=32'h8000_0100.
- Both ecall and mret asserted: ecall priority still gives 32'h8000_0100.
- mret with trap_target=32'h8000_0043: next addr=32'h8000_0040, alignment forced.
- Wrap: pc=32'hFFFF_FFFC, no branch -> next addr=32'h0000_0000.
- Reset asserted in WAIT before the response: back to BOOT, pc=RESET_PC, instret=0; a late rsp_valid in REQ is ignored.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared constants for the instruction-fetch PC sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package ifu_pkg;

    // Fetch FSM encodings, kept as plain 2-bit constants for older consumers
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_EXEC = 2'd3;

    // First fetch address after reset
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    // addi x0, x0, 0 -- harmless filler until the first real fetch lands
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Sequential fetch stride in bytes
    localparam int PC_STEP = 4;

endpackage

// File: rtl/ifu_next_pc.sv
// Next-PC select: trap redirect (ecall > mret) > taken branch > pc+4, word aligned.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
module ifu_next_pc
    import ifu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jump_ecall,
    input  logic            jump_mret,
    input  logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] seq_pc;

    // pc+4 wraps naturally at the top of the address space
    assign seq_pc = pc + XLEN'(PC_STEP);

    // Priority mux: either trap flavour beats a branch, both read the CSR data
    always_comb begin
        sel_pc = seq_pc;
        if (jump_ecall) begin
            sel_pc = trap_target;
        end else if (jump_mret) begin
            sel_pc = trap_target;
        end else if (br_taken) begin
            sel_pc = br_target;
        end
    end

    // Low two bits cleared so a misaligned CSR/branch value still fetches a word
    assign next_pc = sel_pc & ~XLEN'(3);

endmodule

// File: rtl/ifu_pc_seq.sv
// Multi-cycle fetch sequencer: PC register, imem request/response, inst hold, instret.
// Latency: 3 cycles per instruction minimum (REQ -> WAIT -> EXEC -> REQ).
// Backpressure: request held stable until imem_req_ready; WAIT/EXEC stall indefinitely.
module ifu_pc_seq
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,

    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,

    output logic [XLEN-1:0] pc,
    output logic [31:0]     inst,
    output logic            inst_valid,

    input  logic            exec_done,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jump_ecall,
    input  logic            jump_mret,
    input  logic [XLEN-1:0] trap_target,

    output logic [63:0]     instret
);

    logic [1:0]      state;
    logic [XLEN-1:0] next_pc;

    // Redirect inputs only matter on the commit cycle; the mux output is
    // ignored everywhere else, so it is fed unconditionally.
    ifu_next_pc #(
        .XLEN (XLEN)
    ) u_next_pc (
        .pc          (pc),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump_ecall  (jump_ecall),
        .jump_mret   (jump_mret),
        .trap_target (trap_target),
        .next_pc     (next_pc)
    );

    // FSM plus PC/inst/instret registers; reset wins in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_BOOT;
            pc      <= RESET_PC;
            inst    <= NOP_INST;
            instret <= 64'd0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_req_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Responses are only ever accepted here, so anything
                    // arriving in another state is simply dropped.
                    if (imem_rsp_valid) begin
                        inst  <= imem_rsp_data;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        pc      <= next_pc;
                        instret <= instret + 64'd1;
                        state   <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

    // Moore outputs: request side depends on state and pc only, never on imem_rsp_*
    assign imem_req_valid = (state == ST_REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == ST_EXEC);

endmodule

// File: tb/tb_ifu_pc_seq.sv
module tb_ifu_pc_seq;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        exec_done;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump_ecall;
    logic        jump_mret;
    logic [31:0] trap_target;
    logic [63:0] instret;

    int          n_checks;
    int          n_errors;
    int          cyc;
    int          cyc0;
    logic [63:0] exp_instret;

    ifu_pc_seq #(
        .XLEN     (32),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .pc             (pc),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .exec_done      (exec_done),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .jump_ecall     (jump_ecall),
        .jump_mret      (jump_mret),
        .trap_target    (trap_target),
        .instret        (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction from REQ back to REQ with zero-wait memory and
    // exec_done on the first EXEC cycle. Entered and left in REQ.
    task automatic run_instr(input logic [31:0] exp_addr, input logic [31:0] data,
                             input logic ecall, input logic mret,
                             input logic br, input logic [31:0] ttgt,
                             input logic [31:0] btgt);
        chk("req_valid", 64'(imem_req_valid), 64'd1);
        chk("req_addr", 64'(imem_req_addr), 64'(exp_addr));
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
        chk("exec_inst_valid", 64'(inst_valid), 64'd1);
        chk("exec_inst", 64'(inst), 64'(data));
        chk("exec_pc", 64'(pc), 64'(exp_addr));
        exec_done   = 1'b1;
        jump_ecall  = ecall;
        jump_mret   = mret;
        br_taken    = br;
        trap_target = ttgt;
        br_target   = btgt;
        step();
        exec_done   = 1'b0;
        jump_ecall  = 1'b0;
        jump_mret   = 1'b0;
        br_taken    = 1'b0;
        exp_instret = exp_instret + 64'd1;
        chk("instret", instret, exp_instret);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        cyc            = 0;
        exp_instret    = 64'd0;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        exec_done      = 1'b0;
        br_taken       = 1'b0;
        br_target      = 32'h0;
        jump_ecall     = 1'b0;
        jump_mret      = 1'b0;
        trap_target    = 32'h0;

        // Reset for two cycles, then idle memory
        step();
        step();
        rst = 1'b0;
        chk("boot_req_valid", 64'(imem_req_valid), 64'd0);
        chk("boot_inst_valid", 64'(inst_valid), 64'd0);
        chk("boot_pc", 64'(pc), 64'h8000_0000);
        chk("boot_addr", 64'(imem_req_addr), 64'h8000_0000);
        chk("boot_inst", 64'(inst), 64'h13);
        chk("boot_instret", instret, 64'd0);
        step();
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", 64'(imem_req_addr), 64'h8000_0000);

        // Three zero-wait sequential instructions, one every 3 cycles
        cyc0 = cyc;
        run_instr(32'h8000_0000, 32'h0000_0093, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_instr(32'h8000_0004, 32'h0000_0113, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_instr(32'h8000_0008, 32'h0000_0193, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("three_instr_cycles", 64'(cyc - cyc0), 64'd9);
        chk("instret_3", instret, 64'd3);

        // Request backpressure for 4 cycles, with a stray response in REQ
        for (int i = 0; i < 4; i++) begin
            imem_rsp_valid = (i == 1);
            imem_rsp_data  = 32'hDEAD_BEEF;
            step();
            chk("bp_req_valid", 64'(imem_req_valid), 64'd1);
            chk("bp_req_addr", 64'(imem_req_addr), 64'h8000_000C);
        end
        imem_rsp_valid = 1'b0;
        chk("stray_rsp_inst", 64'(inst), 64'h0000_0193);

        // Accept, then response 5 cycles after acceptance
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wait_inst_valid", 64'(inst_valid), 64'd0);
            chk("wait_req_valid", 64'(imem_req_valid), 64'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0213;
        step();
        imem_rsp_valid = 1'b0;
        chk("late_rsp_inst_valid", 64'(inst_valid), 64'd1);
        chk("late_rsp_inst", 64'(inst), 64'h0000_0213);

        // Stall in EXEC: redirect inputs and stray response must be ignored
        br_taken       = 1'b1;
        br_target      = 32'h1234_5678;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        step();
        step();
        br_taken       = 1'b0;
        imem_rsp_valid = 1'b0;
        chk("stall_inst_valid", 64'(inst_valid), 64'd1);
        chk("stall_inst", 64'(inst), 64'h0000_0213);
        chk("stall_pc", 64'(pc), 64'h8000_000C);
        chk("stall_instret", instret, 64'd3);
        exec_done = 1'b1;
        step();
        exec_done   = 1'b0;
        exp_instret = exp_instret + 64'd1;

        // ecall with a taken branch: trap target wins
        run_instr(32'h8000_0010, 32'h0000_0073, 1'b1, 1'b0, 1'b1, 32'h8000_0100, 32'h8000_0200);
        chk("ecall_addr", 64'(imem_req_addr), 64'h8000_0100);

        // ecall and mret together: ecall priority
        run_instr(32'h8000_0100, 32'h0000_0073, 1'b1, 1'b1, 1'b0, 32'h8000_0100, 32'h0);
        chk("ecall_mret_addr", 64'(imem_req_addr), 64'h8000_0100);

        // mret with a misaligned mepc
        run_instr(32'h8000_0100, 32'h3020_0073, 1'b0, 1'b1, 1'b1, 32'h8000_0043, 32'h8000_0200);
        chk("mret_align_addr", 64'(imem_req_addr), 64'h8000_0040);

        // Branch to the top word, then sequential wrap to zero
        run_instr(32'h8000_0040, 32'h0000_006F, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
        chk("branch_addr", 64'(imem_req_addr), 64'hFFFF_FFFC);
        run_instr(32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap_addr", 64'(imem_req_addr), 64'h0000_0000);
        chk("instret_9", instret, 64'd9);

        // Reset while waiting for a response
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("pre_rst_wait", 64'(imem_req_valid), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_pc", 64'(pc), 64'h8000_0000);
        chk("rst_inst", 64'(inst), 64'h13);
        chk("rst_instret", instret, 64'd0);
        step();
        chk("rst_req_again", 64'(imem_req_valid), 64'd1);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        step();
        imem_rsp_valid = 1'b0;
        chk("rst_late_rsp_req", 64'(imem_req_valid), 64'd1);
        chk("rst_late_rsp_inst", 64'(inst), 64'h13);
        chk("rst_late_rsp_addr", 64'(imem_req_addr), 64'h8000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
